// File: rtl/prefix_step_sequencer_if.sv
// Operand/result handshake bundle for the stepped prefix adder.
// Upstream drives the operand side, downstream consumes sum/cout.
interface prefix_step_sequencer_if #(
   parameter int WIDTH = 17
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout
   );
endinterface

// File: rtl/prefix_step_sequencer.sv
// Mantissa adder: one prefix-combine stage reused per clock,
// span doubling each step until every carry is resolved.
module prefix_step_sequencer #(
   parameter int WIDTH = 17,
   parameter int STEPS = 5,
   localparam int SW = $clog2(STEPS + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   prefix_step_sequencer_if.slave bus,
   output logic [SW-1:0]       step
);

   if (((1 << STEPS) < WIDTH) || ((1 << (STEPS - 1)) >= WIDTH)) begin : g_bad_steps
      $error("STEPS does not match WIDTH");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PREFIX = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

   state_t           state_q, state_d;
   logic [SW-1:0]    step_q, step_d;
   logic [WIDTH-1:0] g_q, p_q, p0_q;
   logic             cin_q;
   logic             in_ready, out_valid, accept;
   logic [31:0]      span;
   logic [WIDTH-1:0] lowmask, g_nx, p_nx, p0_in;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               state_d = PREFIX;
               step_d  = '0;
            end
         end
         PREFIX: begin
            if (step_q == LAST) begin
               state_d = DONE;
               step_d  = '0;
            end else begin
               step_d = step_q + 1'b1;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept = bus.in_valid & in_ready;
   assign p0_in  = bus.a ^ bus.b;

   // Shifted-in zeros leave bits below the span untouched.
   always_comb begin
      span    = 32'd1 << step_q;
      lowmask = ~({WIDTH{1'b1}} << span);
      g_nx    = g_q | (p_q & (g_q << span));
      p_nx    = p_q & ((p_q << span) | lowmask);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         g_q   <= '0;
         p_q   <= '0;
         p0_q  <= '0;
         cin_q <= 1'b0;
      end else if (accept) begin
         p0_q  <= p0_in;
         cin_q <= bus.cin;
         g_q   <= {bus.a[WIDTH-1:1] & bus.b[WIDTH-1:1],
                   (bus.a[0] & bus.b[0]) | (p0_in[0] & bus.cin)};
         p_q   <= {p0_in[WIDTH-1:1], 1'b0};
      end else if (state_q == PREFIX) begin
         g_q <= g_nx;
         p_q <= p_nx;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.sum       = p0_q ^ {g_q[WIDTH-2:0], cin_q};
   assign bus.cout      = g_q[WIDTH-1];
   assign step          = step_q;

endmodule

// File: tb/tb_prefix_step_sequencer.sv
// Directed and random checks of the stepped prefix adder.
// Expected results come from hand values and a+b+cin.
module tb_prefix_step_sequencer;
   localparam int WIDTH = 17;
   localparam int STEPS = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] step;
   int         n_chk = 0;
   int         n_fail = 0;

   prefix_step_sequencer_if #(.WIDTH(WIDTH)) bus ();

   prefix_step_sequencer #(.WIDTH(WIDTH), .STEPS(STEPS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .step  (step)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [16:0] a, input logic [16:0] b,
                         input logic cin);
      int n = 0;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("accept_wait", 32'(n < 20), 32'd1);
      bus.a        = a;
      bus.b        = b;
      bus.cin      = cin;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
      bus.cin      = 1'b0;
   endtask

   // Walks the five prefix steps, then checks the presented result.
   task automatic run_txn(input string tag, input logic [16:0] a,
                          input logic [16:0] b, input logic cin,
                          input logic [17:0] exp);
      accept(a, b, cin);
      for (int s = 0; s < STEPS; s++) begin
         chk({tag, "_step"}, 32'(step), 32'(s));
         chk({tag, "_early"}, 32'(bus.out_valid), 32'd0);
         tick();
      end
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_step0"}, 32'(step), 32'd0);
      chk({tag, "_res"}, 32'({bus.cout, bus.sum}), 32'(exp));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
      chk({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      logic [16:0] ra, rb;
      logic        rc;
      logic [17:0] rexp;
      int          gap;
      int          stall;

      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.out_ready = 1'b0;

      tick();
      tick();
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_sum", 32'(bus.sum), 32'h0);
      chk("rst_cout", 32'(bus.cout), 32'd0);
      chk("rst_step", 32'(step), 32'd0);

      run_txn("wrap", 17'h1FFFF, 17'h00001, 1'b0, 18'h20000);
      run_txn("prop", 17'h0AAAA, 17'h05555, 1'b1, 18'h10000);

      // Backpressure with a competing offer that must be ignored.
      accept(17'h12345, 17'h00FFF, 1'b0);
      for (int s = 0; s < STEPS; s++) tick();
      bus.in_valid = 1'b1;
      bus.a        = 17'h00001;
      bus.b        = 17'h00001;
      for (int s = 0; s < 3; s++) begin
         chk("bp_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_res", 32'({bus.cout, bus.sum}), 32'h13344);
         tick();
      end
      chk("bp_res_end", 32'({bus.cout, bus.sum}), 32'h13344);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("bp_idle", 32'(bus.in_ready), 32'd1);
      chk("bp_drop", 32'(bus.out_valid), 32'd0);

      // Reset while stage 2 is pending.
      accept(17'h1FFFF, 17'h1FFFF, 1'b0);
      tick();
      tick();
      chk("mid_step", 32'(step), 32'd2);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
      chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_sum", 32'(bus.sum), 32'h0);
      chk("mid_cout", 32'(bus.cout), 32'd0);
      chk("mid_step0", 32'(step), 32'd0);
      tick();
      chk("mid_no_valid", 32'(bus.out_valid), 32'd0);
      run_txn("post", 17'd3, 17'd4, 1'b0, 18'h00007);

      for (int t = 0; t < 1000; t++) begin
         ra   = 17'($urandom);
         rb   = 17'($urandom);
         rc   = 1'($urandom);
         rexp = {1'b0, ra} + {1'b0, rb} + {17'd0, rc};
         accept(ra, rb, rc);
         gap = 0;
         while (bus.out_valid !== 1'b1 && gap < 20) begin
            tick();
            gap++;
         end
         chk("rnd_gap", 32'(gap), 32'd5);
         stall = int'($urandom_range(0, 3));
         for (int s = 0; s < stall; s++) tick();
         chk("rnd_res", 32'({bus.cout, bus.sum}), 32'(rexp));
         bus.out_ready = 1'b1;
         tick();
         bus.out_ready = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/prefix_step_sequencer.md
# prefix_step_sequencer

Multi-cycle 17-bit integer adder for the floating-point adder's mantissa path. It owns one registered generate/propagate (G/P) vector and runs it through log2 prefix-combine stages, one stage per clock, with span 1, 2, 4, 8, 16. A single stage's worth of combine logic is reused on every step instead of instantiating a full parallel-prefix tree. It sits between the alignment logic (upstream, valid/ready) and the normalisation logic (downstream, valid/ready).

## Interface
- WIDTH, 17, operand width in bits.
- STEPS, 5, number of prefix stages. Legal only if 2^STEPS >= WIDTH and 2^(STEPS-1) < WIDTH. Elaboration fails otherwise.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  addend.
- b  in  WIDTH  addend.
- cin  in  1  carry-in.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  (a+b+cin) mod 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- step  out  clog2(STEPS+1)  current stage index, for debug; 0 outside PREFIX.

## Operation
- G/P pair per bit: {G,P}. Combine hi∘lo = {G_hi | (P_hi & G_lo), P_hi & P_lo}.
- Accept (in_valid & in_ready):
  - latch p0[i] = a[i]^b[i] and cin_r = cin.
  - Initialise G[i] = a[i]&b[i] and P[i] = p0[i] for i ≥ 1.
  - Bit 0 folds in carry-in: G[0] = (a[0]&b[0]) | (p0[0]&cin), P[0] = 0.
- Stage s uses span d = 2^s:
  - for i ≥ d, new[i] = old[i] ∘ old[i-d].
  - for i < d, new[i] = old[i].
  - All bits update simultaneously from the old vector.
- After STEPS stages, G[i] is the carry out of bit i:
  - carry[0] = cin_r; carry[i] = G[i-1].
  - sum = p0 ^ carry.
  - cout = G[WIDTH-1].
- FSM states:
  - IDLE: in_ready=1. On accept → PREFIX with step=0.
  - PREFIX: apply stage `step`. If step==STEPS-1 → DONE and step returns to 0; else step+1. in_ready=0, out_valid=0. No early exit.
  - DONE: out_valid=1, in_ready=0. On out_ready → IDLE; else hold.
- sum and cout are derived from registered p0, cin_r and G only. They are stable for the whole of DONE.
- in_valid is ignored outside IDLE. a, b and cin are not sampled except on accept.
- Reset mid-operation: the next state is IDLE, whatever the current state. The in-flight result is discarded and never presented.

## Timing
- Reset values: in_ready=1, out_valid=0, step=0, sum=0, cout=0. All G/P, p0 and cin_r registers are cleared to 0.
- Accept at edge k. PREFIX occupies edges k+1..k+STEPS. out_valid rises after edge k+STEPS.
  - Latency is STEPS cycles: 5 at default.
- Handoff at edge m (out_valid & out_ready) → in_ready=1 after edge m.
  - Minimum accept-to-accept spacing is STEPS+2 cycles: 7 at default.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid. All handshake outputs are decoded from state.
- rst_n low overrides every other input on that edge.
- Carry-chain boundaries:
  - Full propagate (all P=1) resolves only after the final stage. No intermediate result may be presented.
  - WIDTH = 2^STEPS-1+... (17) means span 16 touches only bit 16.

## Test plan
- Reset: hold rst_n=0 for 2 cycles, then release -> in_ready=1, out_valid=0, sum=0x00000, cout=0, step=0.
- a=0x1FFFF, b=0x00001, cin=0, accepted at edge k -> step shows 0,1,2,3,4 on edges k+1..k+5. Result is sum=0x00000, cout=1, with out_valid first high after edge k+5.
- a=0x0AAAA, b=0x05555, cin=1 (full-length propagate) -> sum=0x10000, cout=0. sum must not be valid before stage 4 completes.
- Backpressure: a=0x12345, b=0x00FFF, cin=0 with out_ready=0 for 3 cycles in DONE -> sum=0x13344 and cout=0 held stable. in_ready stays 0 and a concurrent in_valid is ignored. out_ready=1 -> IDLE next cycle.
- Reset mid-op: accept a=0x1FFFF, b=0x1FFFF, assert rst_n=0 at step 2 -> after that edge in_ready=1, out_valid=0, sum=0. A following add of 3+4, cin=0, returns sum=0x00007, cout=0.
- Random: 1000 back-to-back transactions with random out_ready stalls, checked against (a+b+cin) -> {cout,sum} equals the 18-bit reference. Every accept-to-valid gap is exactly 5 cycles.
